matmul_seq: RTL and testbench



---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matmul.sv | 71 +++++++
 rtl/matmul_seq.sv | 170 +++++++++++++++++
 tb/tb_matmul_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and width helpers for matmul and matmul_seq
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUT     = 2'd2
    } mm_state_e;

    // Accumulator width: product width plus headroom for summing c1 products.
    function automatic int calc_w_c(input int w_a, input int w_b, input int c1);
        return w_a + w_b + $clog2(c1);
    endfunction

    // One input beat must hold either a full A row or a full B row.
    function automatic int calc_w_in(input int c1, input int w_a, input int c2, input int w_b);
        return (c1 * w_a > c2 * w_b) ? c1 * w_a : c2 * w_b;
    endfunction

endpackage

// File: rtl/matmul.sv
// rtl/matmul.sv - signed matrix multiply C = A*B through a cen-gated pipeline of depth LAT
module matmul
    import matmul_pkg::*;
#(
    parameter int R1  = 8,
    parameter int C1  = 6,
    parameter int R2  = 6,
    parameter int C2  = 8,
    parameter int W_A = 8,
    parameter int W_B = 8,
    parameter int LAT = 2,
    localparam int W_C = calc_w_c(W_A, W_B, C1)
) (
    input  logic                  clk,
    input  logic                  rst,   // synchronous, active high
    input  logic                  cen,   // advances the pipeline; C holds while low
    input  logic [R1*C1*W_A-1:0]  a,     // A[i][j] at (i*C1+j)*W_A
    input  logic [R2*C2*W_B-1:0]  b,     // B[i][j] at (i*C2+j)*W_B
    output logic [R1*C2*W_C-1:0]  c      // C[i][j] at (i*C2+j)*W_C
);

    logic signed [W_A-1:0] a_el;
    logic signed [W_B-1:0] b_el;
    logic signed [W_C-1:0] a_ext;
    logic signed [W_C-1:0] b_ext;
    logic signed [W_C-1:0] acc;
    logic [R1*C2*W_C-1:0]  prod;
    logic [R1*C2*W_C-1:0]  pipe [LAT];

    // W_C is sized so the dot product never overflows, so truncating the
    // W_C x W_C product back to W_C bits is exact.
    always_comb begin
        prod  = '0;
        a_el  = '0;
        b_el  = '0;
        a_ext = '0;
        b_ext = '0;
        acc   = '0;
        for (int i = 0; i < R1; i++) begin
            for (int j = 0; j < C2; j++) begin
                acc = '0;
                for (int kk = 0; kk < C1; kk++) begin
                    a_el  = a[(i*C1+kk)*W_A +: W_A];
                    b_el  = b[(kk*C2+j)*W_B +: W_B];
                    a_ext = {{(W_C-W_A){a_el[W_A-1]}}, a_el};
                    b_ext = {{(W_C-W_B){b_el[W_B-1]}}, b_el};
                    acc   = acc + a_ext * b_ext;
                end
                prod[(i*C2+j)*W_C +: W_C] = acc;
            end
        end
    end

    // A and B are held constant while cen is high, so after LAT enabled
    // cycles every stage carries the same, complete result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                pipe[s] <= '0;
            end
        end else if (cen) begin
            pipe[0] <= prod;
            for (int s = 1; s < LAT; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    assign c = pipe[LAT-1];

endmodule

// File: rtl/matmul_seq.sv
// rtl/matmul_seq.sv - stream-fed load/compute/output sequencer around the matmul datapath
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int R1     = 8,
    parameter int C1     = 6,
    parameter int R2     = 6,
    parameter int C2     = 8,
    parameter int W_A    = 8,
    parameter int W_B    = 8,
    parameter int MM_LAT = 2,
    localparam int W_C   = calc_w_c(W_A, W_B, C1),
    localparam int W_IN  = calc_w_in(C1, W_A, C2, W_B)
) (
    input  logic                 clk,
    input  logic                 rst,      // synchronous, active high
    input  logic                 s_valid,  // input row beat valid
    output logic                 s_ready,  // high in LOAD only
    input  logic [W_IN-1:0]      s_data,   // one A or B row, element j at [j*W+:W]
    input  logic                 s_last,   // final beat of a frame
    output logic                 m_valid,  // C row valid
    input  logic                 m_ready,  // downstream accepts
    output logic [C2*W_C-1:0]    m_data,   // C row r, element j at [j*W_C+:W_C]
    output logic                 m_last,   // with row R1-1
    output logic                 busy,     // COMPUTE or OUT
    output logic                 err       // one-cycle framing error pulse
);

    localparam int KW = $clog2(R1 + R2);
    localparam int RW = (R1 > 1) ? $clog2(R1) : 1;
    localparam int LW = (MM_LAT > 1) ? $clog2(MM_LAT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(R1 + R2 - 1);
    localparam logic [RW-1:0] R_LAST = RW'(R1 - 1);
    localparam logic [LW-1:0] L_LAST = LW'(MM_LAT - 1);

    mm_state_e state;
    mm_state_e state_nxt;

    logic [KW-1:0]          k;
    logic [RW-1:0]          r;
    logic [LW-1:0]          lat;
    logic [R1*C1*W_A-1:0]   a_bank;
    logic [R2*C2*W_B-1:0]   b_bank;
    logic [R1*C2*W_C-1:0]   c_all;
    logic                   cen;
    logic                   err_q;

    logic s_fire;
    logic beat_last;
    logic frame_bad;
    logic frame_done;
    logic lat_done;
    logic m_fire;
    logic out_done;

    assign s_fire     = (state == LOAD) && s_valid;
    assign beat_last  = (k == K_LAST);
    assign frame_bad  = s_fire && (s_last != beat_last);
    assign frame_done = s_fire && s_last && beat_last;
    assign lat_done   = (state == COMPUTE) && (lat == L_LAST);
    assign m_fire     = (state == OUT) && m_ready;
    assign out_done   = m_fire && (r == R_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (frame_done) state_nxt = COMPUTE;
            COMPUTE: if (lat_done)   state_nxt = OUT;
            OUT:     if (out_done)   state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        cen     = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        busy    = 1'b0;
        unique case (state)
            LOAD: begin
                s_ready = 1'b1;
            end
            COMPUTE: begin
                cen  = 1'b1;
                busy = 1'b1;
            end
            OUT: begin
                m_valid = 1'b1;
                m_last  = (r == R_LAST);
                busy    = 1'b1;
            end
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

    // A bad beat still lands in a bank; that is harmless because a frame
    // only reaches COMPUTE after every row has been rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            r      <= '0;
            lat    <= '0;
            err_q  <= 1'b0;
            a_bank <= '0;
            b_bank <= '0;
        end else begin
            err_q <= frame_bad;
            if (s_fire) begin
                k <= (frame_bad || frame_done) ? '0 : k + 1'b1;
                for (int i = 0; i < R1; i++) begin
                    if (k == KW'(i)) begin
                        a_bank[i*C1*W_A +: C1*W_A] <= s_data[C1*W_A-1:0];
                    end
                end
                for (int i = 0; i < R2; i++) begin
                    if (k == KW'(R1 + i)) begin
                        b_bank[i*C2*W_B +: C2*W_B] <= s_data[C2*W_B-1:0];
                    end
                end
            end
            if (state == COMPUTE) begin
                lat <= lat_done ? '0 : lat + 1'b1;
            end
            if (m_fire) begin
                r <= out_done ? '0 : r + 1'b1;
            end
        end
    end

    assign err = err_q;

    // r and c_all only change on a handshake, so m_data is stable under backpressure.
    always_comb begin
        m_data = '0;
        for (int i = 0; i < R1; i++) begin
            if (r == RW'(i)) begin
                m_data = c_all[i*C2*W_C +: C2*W_C];
            end
        end
    end

    matmul #(
        .R1  (R1),
        .C1  (C1),
        .R2  (R2),
        .C2  (C2),
        .W_A (W_A),
        .W_B (W_B),
        .LAT (MM_LAT)
    ) u_matmul (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .a   (a_bank),
        .b   (b_bank),
        .c   (c_all)
    );

endmodule

// File: tb/tb_matmul_seq.sv
// tb/tb_matmul_seq.sv - randomized self-checking bench for matmul_seq against an integer matrix model
`timescale 1ns/1ps
module tb_matmul_seq;
    import matmul_pkg::*;

    localparam int R1     = 2;
    localparam int C1     = 2;
    localparam int R2     = 2;
    localparam int C2     = 2;
    localparam int W_A    = 8;
    localparam int W_B    = 8;
    localparam int MM_LAT = 2;
    localparam int W_C    = calc_w_c(W_A, W_B, C1);
    localparam int W_IN   = calc_w_in(C1, W_A, C2, W_B);
    localparam int ROW_W  = C2 * W_C;
    localparam int NBEAT  = R1 + R2;
    localparam int NRAND  = 20;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_last  = 1'b0;
    logic [W_IN-1:0]  s_data  = '0;
    logic             m_ready = 1'b1;
    logic             s_ready;
    logic             m_valid;
    logic             m_last;
    logic             busy;
    logic             err;
    logic [ROW_W-1:0] m_data;

    int n_checks  = 0;
    int n_pass    = 0;
    int wr_ptr    = 0;
    int rd_ptr    = 0;
    int out_row   = 0;
    int rows_seen = 0;
    int cen_cycles = 0;
    logic prev_stall = 1'b0;
    logic [ROW_W+1:0] prev_obs = '0;
    bit stop_rand = 1'b0;

    int a_m [R1][C1];
    int b_m [R2][C2];
    logic [ROW_W-1:0] exp_rows [64][R1];

    always #5 clk = ~clk;

    matmul_seq #(
        .R1(R1), .C1(C1), .R2(R2), .C2(C2),
        .W_A(W_A), .W_B(W_B), .MM_LAT(MM_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy),
        .err     (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W_IN-1:0] beat_data(input int idx);
        logic [W_IN-1:0] v;
        v = '0;
        if (idx < R1) begin
            for (int j = 0; j < C1; j++) v[j*W_A +: W_A] = W_A'(a_m[idx][j]);
        end else begin
            for (int j = 0; j < C2; j++) v[j*W_B +: W_B] = W_B'(b_m[idx-R1][j]);
        end
        return v;
    endfunction

    // Reference: plain integer dot products, truncated to the output field width.
    function automatic logic [ROW_W-1:0] row_exp(input int i);
        logic [ROW_W-1:0] v;
        int sum;
        v = '0;
        for (int j = 0; j < C2; j++) begin
            sum = 0;
            for (int kk = 0; kk < C1; kk++) sum += a_m[i][kk] * b_m[kk][j];
            v[j*W_C +: W_C] = W_C'(sum);
        end
        return v;
    endfunction

    task automatic push_expected();
        for (int i = 0; i < R1; i++) exp_rows[wr_ptr][i] = row_exp(i);
        wr_ptr++;
    endtask

    task automatic rand_mats();
        for (int i = 0; i < R1; i++)
            for (int j = 0; j < C1; j++) a_m[i][j] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < R2; i++)
            for (int j = 0; j < C2; j++) b_m[i][j] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Returns one cycle after the last beat was accepted (cycle t+1).
    task automatic send_beats(input int nbeats, input int last_at, input int gap_pct);
        int  wait_cyc;
        bit  done;
        for (int i = 0; i < nbeats; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid  = 1'b1;
            s_data   = beat_data(i);
            s_last   = (i == last_at);
            done     = 1'b0;
            wait_cyc = 0;
            while (!done && wait_cyc < 500) begin
                @(negedge clk);
                if (s_ready) done = 1'b1;
                @(posedge clk); #1;
                wait_cyc++;
            end
            check("s_accept", done, 1);
            if (!done) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (!m_valid && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("m_valid_seen", m_valid, 1);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (rd_ptr != wr_ptr && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", rd_ptr, wr_ptr);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cen"}, dut.cen, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_err_pulse(input string tag, input int cen0);
        @(negedge clk);
        check({tag, "_err_hi"}, err, 1);
        check({tag, "_s_ready"}, s_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_err_lo"}, err, 0);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_no_cen"}, cen_cycles - cen0, 0);
    endtask

    // Output scoreboard: every handshaked row is compared in order, and a
    // stalled row must look identical on the following cycle.
    always @(negedge clk) begin
        if (rst) begin
            rd_ptr     <= wr_ptr;
            out_row    <= 0;
            prev_stall <= 1'b0;
        end else begin
            cen_cycles <= cen_cycles + (dut.cen ? 1 : 0);
            if (prev_stall) check("hold", {m_valid, m_last, m_data}, prev_obs);
            prev_stall <= m_valid && !m_ready;
            prev_obs   <= {m_valid, m_last, m_data};
            if (m_valid && m_ready) begin
                rows_seen <= rows_seen + 1;
                check("row_expected", rd_ptr < wr_ptr, 1);
                if (rd_ptr < wr_ptr) begin
                    check("row_data", m_data, exp_rows[rd_ptr][out_row]);
                    check("row_last", m_last, out_row == R1 - 1);
                    if (out_row == R1 - 1) begin
                        out_row <= 0;
                        rd_ptr  <= rd_ptr + 1;
                    end else begin
                        out_row <= out_row + 1;
                    end
                end
            end
        end
    end

    initial begin
        int first_mv;
        int cen0;
        int rows0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic frame with exact cycle timing.
        a_m = '{'{1, 2}, '{3, 4}};
        b_m = '{'{5, 6}, '{7, 8}};
        push_expected();
        cen0 = cen_cycles;
        send_beats(NBEAT, NBEAT - 1, 0);
        first_mv = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) check("busy_compute", busy, 1);
            if (c == 0) check("s_ready_compute", s_ready, 0);
            if (m_valid && first_mv < 0) first_mv = c;
            if (c == MM_LAT + R1 - 1) check("s_ready_last_row", s_ready, 0);
            if (c == MM_LAT + R1) check("s_ready_after_last", s_ready, 1);
            @(posedge clk); #1;
        end
        check("first_m_valid", first_mv, MM_LAT);
        check("cen_cycles", cen_cycles - cen0, MM_LAT);
        wait_drain(20);

        // Signed extremes.
        a_m = '{'{-1, 0}, '{0, -1}};
        b_m = '{'{127, -128}, '{-128, 127}};
        push_expected();
        send_beats(NBEAT, NBEAT - 1, 0);
        wait_drain(50);

        // Output backpressure on row 0.
        m_ready = 1'b0;
        rand_mats();
        push_expected();
        send_beats(NBEAT, NBEAT - 1, 0);
        wait_valid(20);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_s_ready", s_ready, 0);
            check("bp_m_valid", m_valid, 1);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_drain(50);

        // Early s_last on beat 1, then a good frame.
        rand_mats();
        cen0 = cen_cycles;
        send_beats(2, 1, 0);
        check_err_pulse("early_last", cen0);
        push_expected();
        send_beats(NBEAT, NBEAT - 1, 0);
        wait_drain(50);

        // Missing s_last on the final beat, then a good frame.
        rand_mats();
        cen0 = cen_cycles;
        send_beats(NBEAT, -1, 0);
        check_err_pulse("missing_last", cen0);
        rand_mats();
        push_expected();
        send_beats(NBEAT, NBEAT - 1, 0);
        wait_drain(50);

        // Reset while computing drops the result.
        rand_mats();
        push_expected();
        send_beats(NBEAT, NBEAT - 1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("rst_compute");
        repeat (6) @(posedge clk);
        #1;
        rand_mats();
        push_expected();
        send_beats(NBEAT, NBEAT - 1, 0);
        wait_drain(50);

        // Reset while a row is stalled on the output.
        m_ready = 1'b0;
        rand_mats();
        push_expected();
        send_beats(NBEAT, NBEAT - 1, 0);
        wait_valid(20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("rst_out");
        m_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rand_mats();
        push_expected();
        send_beats(NBEAT, NBEAT - 1, 0);
        wait_drain(50);

        // Random back-to-back frames with random input gaps and output stalls.
        rows0 = rows_seen;
        stop_rand = 1'b0;
        fork
            begin
                for (int f = 0; f < NRAND; f++) begin
                    rand_mats();
                    push_expected();
                    send_beats(NBEAT, NBEAT - 1, 30);
                end
                wait_drain(2000);
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    m_ready = (int'($urandom_range(0, 99)) < 60);
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("rand_rows", rows_seen - rows0, R1 * NRAND);
        check("rand_row_phase", out_row, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
